// File: rtl/contador_multicanal_umbral.sv
// CH independent N-bit up/down counters with per-channel limit, threshold reference and terminal count.
// Optional sticky boundary flag per channel, built only when CONTADOR_OVF_STICKY_EN is defined.
module contador_multicanal_umbral #(
  parameter  int N  = 32,
  parameter  int CH = 4,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [CH-1:0]   i_enable,
  input  logic [CH-1:0]   i_dec,
  input  logic [CH-1:0]   i_load,
  input  logic [CH*N-1:0] i_load_value,
  input  logic [CH-1:0]   i_wrap_mode,
  input  logic            i_cfg_we,
  input  logic [CW-1:0]   i_cfg_ch,
  input  logic            i_cfg_addr,
  input  logic [N-1:0]    i_cfg_data,
  output logic [CH*N-1:0] o_counterN,
  output logic [CH-1:0]   o_threshold,
  output logic [CH-1:0]   o_tc,
  output logic [CH-1:0]   o_ovf_sticky,
  input  logic [CH-1:0]   i_ovf_clear
);

  typedef enum logic {
    CFG_LIMIT = 1'b0,
    CFG_REF   = 1'b1
  } cfg_sel_e;

  logic [N-1:0]  r_cnt   [CH];
  logic [N-1:0]  r_limit [CH];
  logic [N-1:0]  r_ref   [CH];
  logic [CH-1:0] r_threshold;
  logic [CH-1:0] r_tc;

  logic [N-1:0]  w_cnt_nxt   [CH];
  logic [N-1:0]  w_limit_nxt [CH];
  logic [N-1:0]  w_ref_nxt   [CH];
  logic [CH-1:0] w_thr_nxt;
  logic [CH-1:0] w_tc_nxt;

  // Counting always compares against the registered limit, so a config write in
  // the same cycle only takes effect on the following edge.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_limit_nxt[i] = r_limit[i];
      w_ref_nxt[i]   = r_ref[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_tc_nxt[i]    = 1'b0;

      // Addresses at or above CH never match a channel index and are dropped.
      if (i_cfg_we && (i_cfg_ch == CW'(i))) begin
        if (cfg_sel_e'(i_cfg_addr) == CFG_LIMIT) w_limit_nxt[i] = i_cfg_data;
        else                                     w_ref_nxt[i]   = i_cfg_data;
      end

      if (i_load[i]) begin
        w_cnt_nxt[i] = i_load_value[i*N +: N];
      end else if (i_enable[i]) begin
        if (!i_dec[i]) begin
          if (r_cnt[i] >= r_limit[i]) begin
            w_cnt_nxt[i] = i_wrap_mode[i] ? '0 : r_limit[i];
            w_tc_nxt[i]  = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + N'(1);
          end
        end else begin
          if (r_cnt[i] == '0) begin
            w_cnt_nxt[i] = i_wrap_mode[i] ? r_limit[i] : '0;
            w_tc_nxt[i]  = 1'b1;
          end else if (r_cnt[i] > r_limit[i]) begin
            // Out-of-range value left by a load: wrap snaps back into range, saturate walks down.
            w_cnt_nxt[i] = i_wrap_mode[i] ? r_limit[i] : r_cnt[i] - N'(1);
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - N'(1);
          end
        end
      end

      // Built from next-state values so the registered flag matches the registered count and ref.
      w_thr_nxt[i] = (w_cnt_nxt[i] > w_ref_nxt[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the small per-channel
  // register arrays are reset explicitly because limit/ref must come up at all-ones.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < CH; i++) begin
        r_cnt[i]   <= '0;
        r_limit[i] <= '1;
        r_ref[i]   <= '1;
      end
      r_threshold <= '0;
      r_tc        <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        r_cnt[i]   <= w_cnt_nxt[i];
        r_limit[i] <= w_limit_nxt[i];
        r_ref[i]   <= w_ref_nxt[i];
      end
      r_threshold <= w_thr_nxt;
      r_tc        <= w_tc_nxt;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign o_counterN[g*N +: N] = r_cnt[g];
  end

  assign o_threshold = r_threshold;
  assign o_tc        = r_tc;

`ifdef CONTADOR_OVF_STICKY_EN
  logic [CH-1:0] r_ovf_sticky;

  // Set wins over clear when both happen on the same edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_ovf_sticky <= '0;
    else         r_ovf_sticky <= (r_ovf_sticky & ~i_ovf_clear) | w_tc_nxt;
  end

  assign o_ovf_sticky = r_ovf_sticky;
`else
  logic [CH-1:0] w_unused_ovf_clear;

  assign w_unused_ovf_clear = i_ovf_clear;
  assign o_ovf_sticky       = '0;
`endif

endmodule

// File: tb/tb_contador_multicanal_umbral.sv
// Directed self-checking bench for contador_multicanal_umbral at N=8, CH=4.
module tb_contador_multicanal_umbral;

  localparam int N  = 8;
  localparam int CH = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   enable, dec, load, wrap_mode, ovf_clear;
  logic [CH*N-1:0] load_value;
  logic            cfg_we, cfg_addr;
  logic [CW-1:0]   cfg_ch;
  logic [N-1:0]    cfg_data;
  logic [CH*N-1:0] counter_n;
  logic [CH-1:0]   threshold, tc, ovf_sticky;

  int n_cmp = 0;
  int n_err = 0;

`ifdef CONTADOR_OVF_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  contador_multicanal_umbral #(.N(N), .CH(CH)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (enable),
    .i_dec        (dec),
    .i_load       (load),
    .i_load_value (load_value),
    .i_wrap_mode  (wrap_mode),
    .i_cfg_we     (cfg_we),
    .i_cfg_ch     (cfg_ch),
    .i_cfg_addr   (cfg_addr),
    .i_cfg_data   (cfg_data),
    .o_counterN   (counter_n),
    .o_threshold  (threshold),
    .o_tc         (tc),
    .o_ovf_sticky (ovf_sticky),
    .i_ovf_clear  (ovf_clear)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] cnt(input int ch);
    return counter_n[ch*N +: N];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input logic addr, input logic [N-1:0] data);
    cfg_we   = 1'b1;
    cfg_ch   = CW'(ch);
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic idle();
    enable = '0; dec = '0; load = '0; ovf_clear = '0; cfg_we = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_cnt;
    rst = 1'b1; idle(); wrap_mode = '0; load_value = '0;
    cfg_ch = '0; cfg_addr = 1'b0; cfg_data = '0;
    #12;
    check("rst_counter", counter_n, 32'h0);
    check("rst_threshold", threshold, 4'h0);
    check("rst_tc", tc, 4'h0);
    check("rst_sticky", ovf_sticky, 4'h0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Test 1: non-default limit/ref on ch0, count to 5, then reset mid-cycle.
    cfg_write(0, 1'b0, 8'd100);
    cfg_write(0, 1'b1, 8'd2);
    wrap_mode[0] = 1'b1; enable[0] = 1'b1;
    repeat (5) tick();
    check("t1_count5", cnt(0), 8'd5);
    check("t1_thr_ref2", threshold[0], 1'b1);
    #2 rst = 1'b1;
    #1 check("t1_async_rst", cnt(0), 8'd0);
    check("t1_async_rst_thr", threshold[0], 1'b0);
    rst = 1'b0; idle();
    load[0] = 1'b1; load_value[0*N +: N] = 8'd150;
    tick();
    load[0] = 1'b0; enable[0] = 1'b1;
    tick();
    check("t1_limit_reverted", cnt(0), 8'd151);
    check("t1_ref_reverted", threshold[0], 1'b0);
    idle();

    // Test 2: limit 9 on ch1, wrapping up-count over 11 edges.
    cfg_write(1, 1'b0, 8'd9);
    wrap_mode[1] = 1'b1; enable[1] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      exp_cnt = (k < 9) ? N'(k + 1) : ((k == 9) ? 8'd0 : 8'd1);
      check($sformatf("t2_cnt_%0d", k), cnt(1), exp_cnt);
      check($sformatf("t2_tc_%0d", k), tc[1], (k == 9));
      check($sformatf("t2_sticky_%0d", k), ovf_sticky[1], STICKY_ON && (k >= 9));
    end
    idle();
    tick();
    check("t2_sticky_holds", ovf_sticky[1], STICKY_ON);
    ovf_clear[1] = 1'b1;
    tick();
    ovf_clear[1] = 1'b0;
    check("t2_sticky_cleared", ovf_sticky[1], 1'b0);
    check("t2_hold_value", cnt(1), 8'd1);

    // Test 3: ch2 saturating down-count from 2.
    load[2] = 1'b1; load_value[2*N +: N] = 8'd2;
    tick();
    check("t3_loaded", cnt(2), 8'd2);
    load[2] = 1'b0; wrap_mode[2] = 1'b0; dec[2] = 1'b1; enable[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t3_cnt_%0d", k), cnt(2), (k == 0) ? 8'd1 : 8'd0);
      check($sformatf("t3_tc_%0d", k), tc[2], (k >= 2));
    end
    idle();

    // Test 4: threshold on ch3 against ref 100, then ref raised to 200.
    cfg_write(3, 1'b1, 8'd100);
    load[3] = 1'b1; load_value[3*N +: N] = 8'd100;
    tick();
    load[3] = 1'b0;
    check("t4_thr_at_100", threshold[3], 1'b0);
    enable[3] = 1'b1;
    tick();
    enable[3] = 1'b0;
    check("t4_cnt_101", cnt(3), 8'd101);
    check("t4_thr_at_101", threshold[3], 1'b1);
    cfg_write(3, 1'b1, 8'd200);
    check("t4_thr_ref200", threshold[3], 1'b0);

    // Test 5: ch1 load 50 with enable and limit write in the same cycle.
    load[1] = 1'b1; load_value[1*N +: N] = 8'd50; enable[1] = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_addr = 1'b0; cfg_data = 8'd20;
    tick();
    cfg_we = 1'b0; load[1] = 1'b0;
    check("t5_loaded_50", cnt(1), 8'd50);
    check("t5_load_tc", tc[1], 1'b0);
    tick();
    check("t5_wrap_cnt", cnt(1), 8'd0);
    check("t5_wrap_tc", tc[1], 1'b1);
    // Count in the same cycle as a limit write still uses the old limit (20).
    cfg_we = 1'b1; cfg_data = 8'd1;
    tick();
    cfg_we = 1'b0;
    check("t5_old_limit_cnt", cnt(1), 8'd1);
    check("t5_old_limit_tc", tc[1], 1'b0);
    tick();
    check("t5_new_limit_cnt", cnt(1), 8'd0);
    check("t5_new_limit_tc", tc[1], 1'b1);
    idle();

    // Down-count in wrap mode from a loaded value above the limit snaps to the limit.
    load[1] = 1'b1; load_value[1*N +: N] = 8'd7;
    tick();
    load[1] = 1'b0; dec[1] = 1'b1; enable[1] = 1'b1;
    tick();
    check("t5_down_above_limit", cnt(1), 8'd1);
    check("t5_down_above_tc", tc[1], 1'b0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
